// File: rtl/bfp_exponent_tracker_if.sv
// Port bundle of the block-floating-point exponent tracker: stream/control inputs
// from the FFT stage sequencer, stage results out to the scaling shifter.
interface bfp_exponent_tracker_if #(
    parameter int FFT_DW            = 16,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int NUM_CH            = 2,
    parameter int EXP_W             = 8
);
    // sample_valid qualifies sample_data for one cycle; there is no ready,
    // the tracker accepts every qualified sample and every stage_done while a frame
    // is open. bw_valid / frame_done are single-cycle pulses, results hold between them.
    logic                                    mode;
    logic                                    init;
    logic                                    sample_valid;
    logic [NUM_CH*FFT_DW-1:0]                sample_data;
    logic                                    stage_done;
    logic                                    bw_valid;
    logic                                    frame_done;
    logic [FFT_MAX_BIT_WIDTH-1:0]            stage_idx;
    logic [NUM_CH*FFT_MAX_BIT_WIDTH-1:0]     bfp_bw;
    logic [NUM_CH*(FFT_MAX_BIT_WIDTH+1)-1:0] bfp_scale;
    logic [NUM_CH*EXP_W-1:0]                 bfp_exponent;
    logic [NUM_CH-1:0]                       exp_sat;
    logic [1:0]                              dbg_state;

    modport master (
        output mode, init, sample_valid, sample_data, stage_done,
        input  bw_valid, frame_done, stage_idx, bfp_bw, bfp_scale, bfp_exponent,
               exp_sat, dbg_state
    );

    modport slave (
        input  mode, init, sample_valid, sample_data, stage_done,
        output bw_valid, frame_done, stage_idx, bfp_bw, bfp_scale, bfp_exponent,
               exp_sat, dbg_state
    );
endinterface

// File: rtl/bfp_exponent_tracker.sv
// Per-channel max signed bit width over one FFT stage, turned into a scale shift and
// a running (adaptive) or constant (fixed) block exponent; sequences NUM_STAGES stages.
module bfp_exponent_tracker #(
    parameter int FFT_DW            = 16,
    parameter int FFT_MAX_BIT_WIDTH = 5,
    parameter int NUM_CH            = 2,
    parameter int NUM_STAGES        = 10,
    parameter int EXP_W             = 8,
    parameter int FIXED_EXP         = -3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    bfp_exponent_tracker_if.slave  bus
);
    localparam int MBW = FFT_MAX_BIT_WIDTH;
    localparam int SW  = FFT_MAX_BIT_WIDTH + 1;
    localparam logic signed [SW-1:0] SCALE_BASE   = SW'(FFT_DW - 2);
    localparam logic [EXP_W-1:0]     FIXED_EXP_V  = EXP_W'(FIXED_EXP);
    localparam logic [MBW-1:0]       LAST_IDX     = MBW'(NUM_STAGES - 1);
    localparam logic [EXP_W-1:0]     EXP_MAX      = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0]     EXP_MIN      = {1'b1, {(EXP_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_mode;
    logic               r_first;
    logic               r_bw_valid;
    logic               r_frame_done;
    logic [MBW-1:0]     r_stage_idx;
    logic [MBW-1:0]     r_acc   [NUM_CH];
    logic [MBW-1:0]     r_bw    [NUM_CH];
    logic [SW-1:0]      r_scale [NUM_CH];
    logic [EXP_W-1:0]   r_exp   [NUM_CH];
    logic [NUM_CH-1:0]  r_sat;

    logic [MBW-1:0]          w_sample_bw [NUM_CH];
    logic [MBW-1:0]          w_stage_bw  [NUM_CH];
    logic signed [SW-1:0]    w_scale     [NUM_CH];
    logic signed [EXP_W:0]   w_base      [NUM_CH];
    logic signed [EXP_W:0]   w_sum       [NUM_CH];
    logic [EXP_W-1:0]        w_next_exp  [NUM_CH];
    logic [NUM_CH-1:0]       w_ovf;

    // Negative values are folded with ~x so that -1 -> 1 and -2^(DW-1) -> DW.
    function automatic logic [MBW-1:0] f_bw(input logic [FFT_DW-1:0] x);
        logic [FFT_DW-1:0] v;
        logic [MBW-1:0]    p;
        v = x[FFT_DW-1] ? ~x : x;
        p = '0;
        for (int i = 0; i < FFT_DW; i++) begin
            if (v[i]) p = MBW'(i + 1);
        end
        if (x == '0) return '0;
        return p + MBW'(1);
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sample_bw[c] = f_bw(bus.sample_data[c*FFT_DW +: FFT_DW]);
            w_stage_bw[c]  = (bus.sample_valid && (w_sample_bw[c] > r_acc[c]))
                             ? w_sample_bw[c] : r_acc[c];
            w_scale[c]     = (w_stage_bw[c] == '0) ? '0
                             : SCALE_BASE - $signed({1'b0, w_stage_bw[c]});
            w_base[c]      = r_first ? '0 : {r_exp[c][EXP_W-1], r_exp[c]};
            w_sum[c]       = w_base[c] - {{(EXP_W-MBW){w_scale[c][SW-1]}}, w_scale[c]};
            // Extended sum leaves the EXP_W range exactly when its top two bits differ.
            w_ovf[c]       = w_sum[c][EXP_W] ^ w_sum[c][EXP_W-1];
            if (!r_mode)
                w_next_exp[c] = FIXED_EXP_V;
            else if (w_ovf[c])
                w_next_exp[c] = w_sum[c][EXP_W] ? EXP_MIN : EXP_MAX;
            else
                w_next_exp[c] = w_sum[c][EXP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_first      <= 1'b0;
            r_bw_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_stage_idx  <= '0;
            r_sat        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c]   <= '0;
                r_bw[c]    <= '0;
                r_scale[c] <= '0;
                r_exp[c]   <= '0;
            end
        end else begin
            r_bw_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.init) begin
                r_state     <= S_ACCUM;
                r_mode      <= bus.mode;
                r_first     <= 1'b1;
                r_stage_idx <= '0;
                r_sat       <= '0;
                for (int c = 0; c < NUM_CH; c++)
                    r_acc[c] <= bus.sample_valid ? w_sample_bw[c] : '0;
            end else if (r_state == S_ACCUM) begin
                if (bus.stage_done) begin
                    r_bw_valid  <= 1'b1;
                    r_first     <= 1'b0;
                    r_stage_idx <= r_stage_idx + MBW'(1);
                    for (int c = 0; c < NUM_CH; c++) begin
                        r_acc[c]   <= '0;
                        r_bw[c]    <= w_stage_bw[c];
                        r_scale[c] <= w_scale[c];
                        r_exp[c]   <= w_next_exp[c];
                    end
                    r_sat <= r_sat | (w_ovf & {NUM_CH{r_mode}});
                    if (r_stage_idx == LAST_IDX) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end else if (bus.sample_valid) begin
                    for (int c = 0; c < NUM_CH; c++)
                        r_acc[c] <= w_stage_bw[c];
                end
            end
        end
    end

    assign bus.bw_valid   = r_bw_valid;
    assign bus.frame_done = r_frame_done;
    assign bus.stage_idx  = r_stage_idx;
    assign bus.exp_sat    = r_sat;
    assign bus.dbg_state  = r_state;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.bfp_bw[g*MBW +: MBW]           = r_bw[g];
        assign bus.bfp_scale[g*SW +: SW]          = r_scale[g];
        assign bus.bfp_exponent[g*EXP_W +: EXP_W] = r_exp[g];
    end
endmodule

// File: tb/tb_bfp_exponent_tracker.sv
// Directed bench for bfp_exponent_tracker: vector table for the bit-width/accumulation
// path, hand sequences for frame length, saturation and asynchronous reset.
module tb_bfp_exponent_tracker;
    localparam int DW  = 16;
    localparam int MBW = 5;
    localparam int NCH = 2;
    localparam int EW  = 8;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    bfp_exponent_tracker_if #(.FFT_DW(DW), .FFT_MAX_BIT_WIDTH(MBW), .NUM_CH(NCH), .EXP_W(EW)) bus ();

    bfp_exponent_tracker #(
        .FFT_DW(DW), .FFT_MAX_BIT_WIDTH(MBW), .NUM_CH(NCH),
        .NUM_STAGES(10), .EXP_W(EW), .FIXED_EXP(-3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        init;
        logic        mode;
        logic        sv;
        logic [31:0] data;
        logic        sd;
        logic        vld;
        logic        fd;
        logic [4:0]  idx;
        logic [9:0]  bw;
        logic [11:0] sc;
        logic [15:0] ex;
        logic [1:0]  sat;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic init, logic mode, logic sv, logic [31:0] data, logic sd,
                                logic vld, logic fd, logic [4:0] idx, logic [9:0] bw,
                                logic [11:0] sc, logic [15:0] ex, logic [1:0] sat, logic [1:0] st);
        vec_t v;
        v.init = init; v.mode = mode; v.sv = sv; v.data = data; v.sd = sd;
        v.vld = vld; v.fd = fd; v.idx = idx; v.bw = bw; v.sc = sc; v.ex = ex;
        v.sat = sat; v.st = st;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic init, logic mode, logic sv, logic [31:0] data, logic sd);
        bus.init         = init;
        bus.mode         = mode;
        bus.sample_valid = sv;
        bus.sample_data  = data;
        bus.stage_done   = sd;
        tick();
        bus.init         = 1'b0;
        bus.sample_valid = 1'b0;
        bus.stage_done   = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic vld, logic fd, logic [4:0] idx, logic [9:0] bw,
                             logic [11:0] sc, logic [15:0] ex, logic [1:0] sat, logic [1:0] st);
        check({tag, ".bw_valid"},     32'(bus.bw_valid),     32'(vld));
        check({tag, ".frame_done"},   32'(bus.frame_done),   32'(fd));
        check({tag, ".stage_idx"},    32'(bus.stage_idx),    32'(idx));
        check({tag, ".bfp_bw"},       32'(bus.bfp_bw),       32'(bw));
        check({tag, ".bfp_scale"},    32'(bus.bfp_scale),    32'(sc));
        check({tag, ".bfp_exponent"}, 32'(bus.bfp_exponent), 32'(ex));
        check({tag, ".exp_sat"},      32'(bus.exp_sat),      32'(sat));
        check({tag, ".state"},        32'(bus.dbg_state),    32'(st));
    endtask

    // ---------------- test ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;

        // Adaptive stages: bw detection, accumulation, same-cycle sample, empty stage, init+stage_done.
        vecs[0]  = mk(1, 1, 0, 32'h0, 0,                    0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd1);
        vecs[1]  = mk(0, 0, 1, {16'hFFFF, 16'h0100}, 0,     0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd1);
        vecs[2]  = mk(0, 0, 1, {16'h0000, 16'hFF00}, 0,     0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd1);
        vecs[3]  = mk(0, 0, 1, {16'h0000, 16'h0003}, 0,     0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd1);
        vecs[4]  = mk(0, 0, 0, 32'h0, 1,                    1, 0, 1, {5'd1, 5'd10}, {6'd13, 6'd4},
                      {8'hF3, 8'hFC}, 2'b00, 2'd1);
        vecs[5]  = mk(0, 0, 1, {16'h0000, 16'h7FFF}, 0,     0, 0, 1, {5'd1, 5'd10}, {6'd13, 6'd4},
                      {8'hF3, 8'hFC}, 2'b00, 2'd1);
        vecs[6]  = mk(0, 0, 0, 32'h0, 1,                    1, 0, 2, {5'd0, 5'd16}, {6'd0, 6'h3E},
                      {8'hF3, 8'hFE}, 2'b00, 2'd1);
        vecs[7]  = mk(0, 0, 1, {16'h0001, 16'h4000}, 1,     1, 0, 3, {5'd2, 5'd16}, {6'd12, 6'h3E},
                      {8'hE7, 8'h00}, 2'b00, 2'd1);
        vecs[8]  = mk(0, 0, 0, 32'h0, 1,                    1, 0, 4, 10'h0, 12'h0, {8'hE7, 8'h00}, 2'b00, 2'd1);
        vecs[9]  = mk(1, 1, 0, 32'h0, 1,                    0, 0, 0, 10'h0, 12'h0, {8'hE7, 8'h00}, 2'b00, 2'd1);
        vecs[10] = mk(0, 0, 0, 32'h0, 0,                    0, 0, 0, 10'h0, 12'h0, {8'hE7, 8'h00}, 2'b00, 2'd1);

        reset_n          = 1'b0;
        bus.init         = 1'b0;
        bus.mode         = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.stage_done   = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd0);
        reset_n = 1'b1;
        drive(0, 0, 1, 32'h1234_5678, 1);
        check_all("idle_ignore", 0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].init, vecs[i].mode, vecs[i].sv, vecs[i].data, vecs[i].sd);
            check_all($sformatf("vec%0d", i), vecs[i].vld, vecs[i].fd, vecs[i].idx, vecs[i].bw,
                      vecs[i].sc, vecs[i].ex, vecs[i].sat, vecs[i].st);
        end

        // Fixed mode: ten back-to-back stages, then an eleventh stage_done and a sample in DONE.
        drive(1, 0, 0, 32'h0, 0);
        for (int s = 1; s <= 10; s++) begin
            drive(0, 0, 0, 32'h0, 1);
            check_all($sformatf("fixed%0d", s), 1, (s == 10), 5'(s), 10'h0, 12'h0,
                      {8'hFD, 8'hFD}, 2'b00, (s == 10) ? 2'd2 : 2'd1);
        end
        drive(0, 0, 1, {16'h7FFF, 16'h7FFF}, 1);
        check_all("fixed11", 0, 0, 5'd10, 10'h0, 12'h0, {8'hFD, 8'hFD}, 2'b00, 2'd2);

        // Adaptive saturation: ch0 = -1 every stage, exponent walks down by 13 and clamps.
        drive(1, 1, 0, 32'h0, 0);
        for (int s = 1; s <= 10; s++) begin
            int e;
            e = -13 * s;
            if (e < -128) e = -128;
            drive(0, 0, 1, {16'h0000, 16'hFFFF}, 0);
            drive(0, 0, 0, 32'h0, 1);
            check_all($sformatf("sat%0d", s), 1, (s == 10), 5'(s), {5'd0, 5'd1}, {6'd0, 6'd13},
                      {8'h00, 8'(e)}, (s == 10) ? 2'b01 : 2'b00, (s == 10) ? 2'd2 : 2'd1);
        end
        drive(1, 1, 0, 32'h0, 0);
        check_all("sat_clear", 0, 0, 0, {5'd0, 5'd1}, {6'd0, 6'd13}, {8'h00, 8'h80}, 2'b00, 2'd1);

        // Random traffic, then reset asserted between clock edges.
        for (int i = 0; i < 8; i++)
            drive(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        #3;
        reset_n = 1'b0;
        #1;
        check_all("midreset", 0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd0);
        tick();
        reset_n = 1'b1;
        drive(0, 1, 0, 32'h0, 1);
        check_all("post_reset", 0, 0, 0, 10'h0, 12'h0, 16'h0, 2'b00, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bfp_exponent_tracker.md
# bfp_exponent_tracker

Multi-channel block-floating-point exponent tracker for the FFT datapath. It measures the per-channel maximum signed bit width of every sample streamed through one FFT stage. At each stage boundary it derives the scale shift and updates a per-channel signed exponent, either adaptively (accumulated) or as a fixed constant. It sits between the butterfly output stream and the stage-scaling shifter, and sequences a complete frame of `NUM_STAGES` stages.

## Interface
- `FFT_DW`, 16: sample width, signed two's complement.
- `FFT_MAX_BIT_WIDTH`, 5: width of a bit-width code; must hold values 0..FFT_DW.
- `NUM_CH`, 2: number of independent channels.
- `NUM_STAGES`, 10: stages per frame.
- `EXP_W`, 8: exponent width, signed.
- `FIXED_EXP`, -3: exponent reported in fixed mode.
- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = fixed exponent, 1 = adaptive; sampled only on `init`.
- `init`  in  1  start a new frame.
- `sample_valid`  in  1  `sample_data` qualifies this cycle.
- `sample_data`  in  NUM_CH*FFT_DW  channel c at `[c*FFT_DW +: FFT_DW]`.
- `stage_done`  in  1  closes the current stage.
- `bw_valid`  out  1  one-cycle pulse: stage results updated.
- `frame_done`  out  1  one-cycle pulse with the last stage's `bw_valid`.
- `stage_idx`  out  FFT_MAX_BIT_WIDTH  stages completed since `init`.
- `bfp_bw`  out  NUM_CH*FFT_MAX_BIT_WIDTH  max bit width of the closed stage.
- `bfp_scale`  out  NUM_CH*(FFT_MAX_BIT_WIDTH+1)  signed scale of the closed stage.
- `bfp_exponent`  out  NUM_CH*EXP_W  signed running exponent.
- `exp_sat`  out  NUM_CH  sticky per-channel exponent-saturation flag.

## Operation
- **States:** IDLE, ACCUM, DONE.
  - IDLE → ACCUM on `init`.
  - ACCUM → DONE when the `NUM_STAGES`-th `stage_done` is accepted.
  - DONE → ACCUM on `init`.
- **Ignored inputs:** in IDLE and DONE, `sample_valid` and `stage_done` are ignored and all outputs hold.
- **Sample bit width:** bw(x) = 0 if x == 0. Otherwise bw(x) = 1 + position of the highest set bit of (x<0 ? ~x : x), counting positions from 1; bw(-1) = 1. Range 0..FFT_DW.
- **Accumulation:** while in ACCUM with `sample_valid`, each channel's accumulator becomes max(acc, bw(sample)).
- **On `init`:**
  - Accumulators clear, then absorb the same-cycle sample if `sample_valid`.
  - `stage_idx` ← 0; `exp_sat` ← 0; `mode` latched; first-stage flag set.
  - Exponents keep their value until the first stage closes.
- **On accepted `stage_done`:**
  - The closing stage's max includes any same-cycle valid sample.
  - `bfp_bw` ← final max.
  - `bfp_scale` ← 0 if bw == 0, else (FFT_DW-2) - bw, giving range FFT_DW-3..-2.
  - Accumulator clears to 0, or to that sample's bw if `sample_valid` is also asserted that cycle? No: the same-cycle sample belongs to the closing stage, so the accumulator clears to 0.
  - `stage_idx` increments.
- **Exponent update:**
  - Fixed mode: `bfp_exponent` ← FIXED_EXP.
  - Adaptive mode, first stage: ← -scale.
  - Adaptive mode, later stages: ← exponent - scale.
  - Arithmetic is done in EXP_W+1 bits and clamped to [-2^(EXP_W-1), 2^(EXP_W-1)-1].
  - On clamp, that channel's `exp_sat` ← 1, held until `init` or reset.
- **Simultaneous `init` + `stage_done`:** `init` wins and `stage_done` is dropped, in every state.
- **Reset (asynchronous, any time, including mid-frame):** all outputs and internal state go to 0 (`exp_sat` = 0, flags 0); state ← IDLE; the frame is abandoned.

## Timing
- Sample-to-accumulator latency: 1 cycle.
- `stage_done` at edge N → `bfp_bw`, `bfp_scale`, `bfp_exponent`, `exp_sat`, `stage_idx` updated and `bw_valid` high for the cycle after edge N. The bw computation is registered in the same cycle (single-stage pipeline).
- `frame_done` is coincident with the final `bw_valid`. The state reads DONE in that same cycle.
- Back-to-back `stage_done` on consecutive cycles is legal. A stage with no samples reports bw = 0, scale = 0.
- Outputs are stable between `bw_valid` pulses.
- No backpressure: the block always accepts samples.

## Test plan
- **Reset values:** assert `reset_n` = 0 mid-frame with random traffic → all outputs 0 within the same cycle, state IDLE. After release, `stage_done` alone produces no `bw_valid`.
- **Bit-width detection:** adaptive mode, FFT_DW = 16, `init`, then samples on ch0 = 0x0100, 0xFF00, 0x0003 and ch1 = 0xFFFF, then `stage_done` → ch0 bw = 10, scale = 4, exponent = -4; ch1 bw = 1, scale = 13, exponent = -13.
- **Accumulation across stages:** on the next stage, ch0 samples max 0x7FFF → bw = 16, scale = -2, exponent = -4 + 2 = -2.
- **Fixed mode and frame length:** fixed mode, 10 `stage_done` pulses → `bfp_exponent` = -3 on every `bw_valid`, `stage_idx` 1..10. `frame_done` occurs only on the 10th pulse; an 11th `stage_done` is ignored.
- **Saturation:** adaptive mode, ch0 sample -1 every stage for 10 stages → exponent -13, -26, …, -117, then -128 with `exp_sat[0]` = 1. A following `init` clears `exp_sat`.
- **Boundary events:**
  - Valid sample 0x4000 on the same cycle as `stage_done` → counted in the closing stage (bw = 16), not the next.
  - `init` + `stage_done` together → no `bw_valid` and `stage_idx` = 0.
